// File: rtl/tpi_profile_ctrl.sv
// Sequencer that sweeps an LFSR pattern set through baseline, fault and fault+control-point phases
// and counts response hits per phase. Optional obs_hits counter enabled by TPI_OBS_CNT_EN.
module tpi_profile_ctrl #(
    parameter int          PATTERNS = 10000,
    parameter int          CNT_W    = 16,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             out_base,
    input  logic             out_tpi,
    input  logic             obs,
    output logic [15:0]      dut_in,
    output logic             test_mode,
    output logic             cp_force_1,
    output logic             fault_enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] base_hits,
    output logic [CNT_W-1:0] nocp_hits,
`ifdef TPI_OBS_CNT_EN
    output logic [CNT_W-1:0] obs_hits,
`endif
    output logic [CNT_W-1:0] cp_hits
);

    typedef enum logic [2:0] {IDLE, BASE, FAULT, CP, DONE} state_t;

    // An all-zero seed would lock the LFSR, so it is swapped for the default.
    localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] pat_cnt;
    logic             last;

    assign last = (pat_cnt == LAST_CNT);

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

`ifndef TPI_OBS_CNT_EN
    logic obs_unused;
    assign obs_unused = obs;
`endif

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state        <= IDLE;
            pat_cnt      <= '0;
            dut_in       <= 16'h0000;
            test_mode    <= 1'b0;
            cp_force_1   <= 1'b0;
            fault_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            base_hits    <= '0;
            nocp_hits    <= '0;
            cp_hits      <= '0;
`ifdef TPI_OBS_CNT_EN
            obs_hits     <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= BASE;
                        pat_cnt   <= '0;
                        dut_in    <= SEED_EFF;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        base_hits <= '0;
                        nocp_hits <= '0;
                        cp_hits   <= '0;
`ifdef TPI_OBS_CNT_EN
                        obs_hits  <= '0;
`endif
                    end
                end
                BASE: begin
                    if (out_base) base_hits <= base_hits + ONE;
                    if (last) begin
                        state        <= FAULT;
                        pat_cnt      <= '0;
                        dut_in       <= SEED_EFF;
                        fault_enable <= 1'b1;
                    end else begin
                        pat_cnt <= pat_cnt + ONE;
                        dut_in  <= lfsr_next(dut_in);
                    end
                end
                FAULT: begin
                    if (out_tpi) nocp_hits <= nocp_hits + ONE;
`ifdef TPI_OBS_CNT_EN
                    if (obs) obs_hits <= obs_hits + ONE;
`endif
                    if (last) begin
                        state      <= CP;
                        pat_cnt    <= '0;
                        dut_in     <= SEED_EFF;
                        test_mode  <= 1'b1;
                        cp_force_1 <= 1'b1;
                    end else begin
                        pat_cnt <= pat_cnt + ONE;
                        dut_in  <= lfsr_next(dut_in);
                    end
                end
                CP: begin
                    if (out_tpi) cp_hits <= cp_hits + ONE;
`ifdef TPI_OBS_CNT_EN
                    if (obs) obs_hits <= obs_hits + ONE;
`endif
                    if (last) begin
                        // dut_in keeps the final pattern while results are read back.
                        state        <= DONE;
                        pat_cnt      <= '0;
                        test_mode    <= 1'b0;
                        cp_force_1   <= 1'b0;
                        fault_enable <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        pat_cnt <= pat_cnt + ONE;
                        dut_in  <= lfsr_next(dut_in);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpi_profile_ctrl.sv
// Directed bench for tpi_profile_ctrl with PATTERNS=4, SEED=16'h0001.
module tb_tpi_profile_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, start, abort, out_base, out_tpi, obs;
    logic [15:0]      dut_in;
    logic             test_mode, cp_force_1, fault_enable, busy, done;
    logic [CNT_W-1:0] base_hits, nocp_hits, cp_hits;
`ifdef TPI_OBS_CNT_EN
    logic [CNT_W-1:0] obs_hits;
`endif
    logic             tie1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Combinational stand-in for the logic cone: hits only on pattern 0004.
    assign out_base = (dut_in == 16'h0004);
    assign out_tpi  = tie1 ? 1'b1 : (dut_in == 16'h0004);
    assign obs      = 1'b1;

    tpi_profile_ctrl #(.PATTERNS(4), .CNT_W(CNT_W), .SEED(16'h0001)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .out_base(out_base), .out_tpi(out_tpi), .obs(obs),
        .dut_in(dut_in), .test_mode(test_mode), .cp_force_1(cp_force_1),
        .fault_enable(fault_enable), .busy(busy), .done(done),
        .base_hits(base_hits), .nocp_hits(nocp_hits),
`ifdef TPI_OBS_CNT_EN
        .obs_hits(obs_hits),
`endif
        .cp_hits(cp_hits)
    );

    typedef struct {
        logic        start;
        logic [15:0] exp_dut;
        logic [2:0]  exp_ctrl;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    function automatic logic [2:0] ctrl();
        return {test_mode, cp_force_1, fault_enable};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; tie1 = 1'b0;

        // Vector k is applied before edge k; expectations hold in cycle k+1.
        vecs[0]  = '{1'b1, 16'h0001, 3'b000, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 16'h0002, 3'b000, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 16'h0004, 3'b000, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 16'h0008, 3'b000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 16'h0001, 3'b001, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 16'h0002, 3'b001, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 16'h0004, 3'b001, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 16'h0008, 3'b001, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 16'h0001, 3'b111, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 16'h0002, 3'b111, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 16'h0004, 3'b111, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 16'h0008, 3'b111, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 16'h0008, 3'b000, 1'b0, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_dut_in", dut_in, 16'h0000);
        chk("rst_ctrl", ctrl(), 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_base_hits", base_hits, 0);
        chk("rst_nocp_hits", nocp_hits, 0);
        chk("rst_cp_hits", cp_hits, 0);

        tick();
        chk("idle_busy", busy, 1'b0);

        // Full run; vector 3 also carries a start while busy, which must be ignored.
        for (int k = 0; k < 13; k++) begin
            start = vecs[k].start;
            tick();
            chk($sformatf("seq%0d_dut_in", k), dut_in, vecs[k].exp_dut);
            chk($sformatf("seq%0d_ctrl", k), ctrl(), vecs[k].exp_ctrl);
            chk($sformatf("seq%0d_busy", k), busy, vecs[k].exp_busy);
            chk($sformatf("seq%0d_done", k), done, vecs[k].exp_done);
        end
        chk("run_base_hits", base_hits, 1);
        chk("run_nocp_hits", nocp_hits, 1);
        chk("run_cp_hits", cp_hits, 1);
`ifdef TPI_OBS_CNT_EN
        chk("run_obs_hits", obs_hits, 8);
`endif

        tick();
        chk("done_hold", done, 1'b1);
        chk("done_hold_cp_hits", cp_hits, 1);

        // Restart from DONE clears counters and re-enters BASE on the next cycle.
        tie1 = 1'b1;
        start = 1'b1;
        tick();
        chk("restart_busy", busy, 1'b1);
        chk("restart_done", done, 1'b0);
        chk("restart_dut_in", dut_in, 16'h0001);
        chk("restart_base_hits", base_hits, 0);
        chk("restart_nocp_hits", nocp_hits, 0);
        chk("restart_cp_hits", cp_hits, 0);

        for (int k = 0; k < 5; k++) tick();
        chk("pre_abort_ctrl", ctrl(), 3'b001);
        chk("pre_abort_nocp_hits", nocp_hits, 1);
        chk("pre_abort_base_hits", base_hits, 1);

        abort = 1'b1;
        tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_ctrl", ctrl(), 3'b000);
        chk("abort_dut_in", dut_in, 16'h0000);
        chk("abort_nocp_hits", nocp_hits, 0);
        chk("abort_base_hits", base_hits, 0);

        // Abort beats start in the same cycle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        chk("start_abort_busy", busy, 1'b0);
        chk("start_abort_dut_in", dut_in, 16'h0000);

        start = 1'b1;
        tick();
        chk("idle_start_busy", busy, 1'b1);
        chk("idle_start_dut_in", dut_in, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
